// File: rtl/dkong3_pkg.sv
// -----------------------------------------------------------------------------
// dkong3_pkg
// Shared constants and types for the Donkey Kong 3 sound-command mailbox.
//   NUM_SND_CH    : number of sound sub-CPU command channels
//   STAT_PEND_LSB : bit position of the pend flags in the status byte
//   STAT_OVR_LSB  : bit position of the overrun flags in the status byte
//   ch_state_e    : per-channel mailbox state (empty / command pending)
// -----------------------------------------------------------------------------
package dkong3_pkg;

   localparam int NUM_SND_CH    = 2;
   localparam int STAT_PEND_LSB = 0;
   localparam int STAT_OVR_LSB  = 4;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_FULL = 1'b1
   } ch_state_e;

endpackage

// File: rtl/dkong3_snd_cmd_latch_if.sv
// -----------------------------------------------------------------------------
// dkong3_snd_cmd_latch_if
// Bus bundle between the main CPU decoder / sub-CPUs and the command mailbox.
//   I_DB          : main CPU data bus (8)
//   I_WR_STB_n    : per-channel write strobe, active-low
//   I_SUB_RESETn  : per-channel sub-CPU reset, active-low
//   I_SUB_RD_n    : per-channel sub-CPU read strobe, active-low
//   I_STAT_RD_n   : main CPU status read strobe, active-low
//   O_SUB_DB      : latched command bytes, channel c at [8c+7:8c]
//   O_SUB_IRQ_n   : per-channel interrupt request, active-low
//   O_PEND        : per-channel command-pending flags
//   O_STAT_DB     : status byte for the main CPU
// Modports: master = CPU/decoder side, slave = mailbox.
// -----------------------------------------------------------------------------
interface dkong3_snd_cmd_latch_if
   import dkong3_pkg::*;
#(
   parameter int NUM_CH = NUM_SND_CH
);

   logic [7:0]          I_DB;
   logic [NUM_CH-1:0]   I_WR_STB_n;
   logic [NUM_CH-1:0]   I_SUB_RESETn;
   logic [NUM_CH-1:0]   I_SUB_RD_n;
   logic                I_STAT_RD_n;
   logic [8*NUM_CH-1:0] O_SUB_DB;
   logic [NUM_CH-1:0]   O_SUB_IRQ_n;
   logic [NUM_CH-1:0]   O_PEND;
   logic [7:0]          O_STAT_DB;

   modport master (
      output I_DB, I_WR_STB_n, I_SUB_RESETn, I_SUB_RD_n, I_STAT_RD_n,
      input  O_SUB_DB, O_SUB_IRQ_n, O_PEND, O_STAT_DB
   );

   modport slave (
      input  I_DB, I_WR_STB_n, I_SUB_RESETn, I_SUB_RD_n, I_STAT_RD_n,
      output O_SUB_DB, O_SUB_IRQ_n, O_PEND, O_STAT_DB
   );

endinterface

// File: rtl/dkong3_snd_cmd_ch.sv
// -----------------------------------------------------------------------------
// dkong3_snd_cmd_ch
// One mailbox channel: command latch, strobe edge detectors, IDLE/FULL state
// and (with DKONG3_SNDLATCH_STATUS_EN) the overrun flag.
//   clk_i, rst_i   : 12 MHz clock, asynchronous active-high reset
//   db_i           : main CPU data bus
//   wr_stb_n_i     : write strobe, active-low (event on falling edge)
//   sub_reset_n_i  : sub-CPU reset, active-low, clears the channel
//   sub_rd_n_i     : sub-CPU read strobe, active-low (ack on rising edge)
//   ovr_clr_i      : one-cycle pulse clearing the overrun flag
//   latch_o        : latched command byte
//   pend_o         : command pending
//   irq_n_o        : interrupt request, active-low
//   ovr_o          : overrun flag (constant 0 without the status build)
// Macro: DKONG3_SNDLATCH_STATUS_EN enables the overrun register.
// -----------------------------------------------------------------------------
module dkong3_snd_cmd_ch
   import dkong3_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] db_i,
   input  logic       wr_stb_n_i,
   input  logic       sub_reset_n_i,
   input  logic       sub_rd_n_i,
   input  logic       ovr_clr_i,
   output logic [7:0] latch_o,
   output logic       pend_o,
   output logic       irq_n_o,
   output logic       ovr_o
);

   ch_state_e  state_q;
   logic [7:0] latch_q;
   logic       wr_prev_q;
   logic       rd_prev_q;
   logic       wr_arm_q;
   logic       wr_fall;
   logic       rd_rise;

   // A strobe still held low when I_RESET releases must not count as a write;
   // the write detector is armed only once the strobe has been sampled high.
   assign wr_fall = wr_arm_q & wr_prev_q & ~wr_stb_n_i;
   assign rd_rise = ~rd_prev_q & sub_rd_n_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= CH_IDLE;
         latch_q   <= 8'h00;
         wr_prev_q <= 1'b1;
         rd_prev_q <= 1'b1;
         wr_arm_q  <= 1'b0;
      end else begin
         // Strobe levels are tracked even during sub reset so that a strobe
         // held low across the sub-reset release does not fire an event.
         wr_prev_q <= wr_stb_n_i;
         rd_prev_q <= sub_rd_n_i;
         if (wr_stb_n_i) begin
            wr_arm_q <= 1'b1;
         end
         if (!sub_reset_n_i) begin
            state_q <= CH_IDLE;
            latch_q <= 8'h00;
         end else begin
            case (state_q)
               CH_IDLE: begin
                  if (wr_fall) begin
                     latch_q <= db_i;
                     state_q <= CH_FULL;
                  end
               end
               CH_FULL: begin
                  // Write beats a simultaneous read ack: stay FULL.
                  if (wr_fall) begin
                     latch_q <= db_i;
                  end else if (rd_rise) begin
                     state_q <= CH_IDLE;
                  end
               end
               default: state_q <= CH_IDLE;
            endcase
         end
      end
   end

   assign latch_o = latch_q;
   assign pend_o  = (state_q == CH_FULL);
   assign irq_n_o = (state_q != CH_FULL);

`ifdef DKONG3_SNDLATCH_STATUS_EN
   logic ovr_q;

   // An overrun in the same cycle as the status-read clear wins.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovr_q <= 1'b0;
      end else if (!sub_reset_n_i) begin
         ovr_q <= 1'b0;
      end else if (wr_fall && (state_q == CH_FULL)) begin
         ovr_q <= 1'b1;
      end else if (ovr_clr_i) begin
         ovr_q <= 1'b0;
      end
   end

   assign ovr_o = ovr_q;
`else
   logic unused_ovr_clr;
   assign unused_ovr_clr = ovr_clr_i;
   assign ovr_o          = 1'b0;
`endif

endmodule

// File: rtl/dkong3_snd_cmd_latch.sv
// -----------------------------------------------------------------------------
// dkong3_snd_cmd_latch
// Sound-command mailbox from the main Z80 to the two 2A03 sound sub-CPUs.
// Ports:
//   I_CLK12M : 12 MHz system clock
//   I_RESET  : asynchronous active-high reset
//   bus      : dkong3_snd_cmd_latch_if.slave (data bus, strobes, sub resets,
//              latched bytes, IRQs, pend flags, status byte)
// Macro: DKONG3_SNDLATCH_STATUS_EN enables overrun flags and the status byte
//        (pend at [NUM_CH-1:0], ovr at [NUM_CH+3:4], read clears ovr).
//        Undefined: status byte is 8'h00 and I_STAT_RD_n is ignored.
// -----------------------------------------------------------------------------
module dkong3_snd_cmd_latch
   import dkong3_pkg::*;
#(
   parameter int NUM_CH = NUM_SND_CH
)(
   input  logic                  I_CLK12M,
   input  logic                  I_RESET,
   dkong3_snd_cmd_latch_if.slave bus
);

   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] ovr;
   logic              ovr_clr;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      dkong3_snd_cmd_ch u_ch (
         .clk_i         (I_CLK12M),
         .rst_i         (I_RESET),
         .db_i          (bus.I_DB),
         .wr_stb_n_i    (bus.I_WR_STB_n[c]),
         .sub_reset_n_i (bus.I_SUB_RESETn[c]),
         .sub_rd_n_i    (bus.I_SUB_RD_n[c]),
         .ovr_clr_i     (ovr_clr),
         .latch_o       (bus.O_SUB_DB[8*c +: 8]),
         .pend_o        (pend[c]),
         .irq_n_o       (bus.O_SUB_IRQ_n[c]),
         .ovr_o         (ovr[c])
      );
   end

   assign bus.O_PEND = pend;

`ifdef DKONG3_SNDLATCH_STATUS_EN
   logic       stat_prev_q;
   logic [7:0] stat_db;

   // The end of a status read (rising edge) clears every overrun flag.
   always_ff @(posedge I_CLK12M or posedge I_RESET) begin
      if (I_RESET) begin
         stat_prev_q <= 1'b1;
      end else begin
         stat_prev_q <= bus.I_STAT_RD_n;
      end
   end

   assign ovr_clr = ~stat_prev_q & bus.I_STAT_RD_n;

   always_comb begin
      stat_db = 8'h00;
      if (!bus.I_STAT_RD_n) begin
         stat_db[STAT_PEND_LSB +: NUM_CH] = pend;
         stat_db[STAT_OVR_LSB  +: NUM_CH] = ovr;
      end
   end

   assign bus.O_STAT_DB = stat_db;
`else
   logic unused_stat;
   assign unused_stat   = bus.I_STAT_RD_n ^ (^ovr);
   assign ovr_clr       = 1'b0;
   assign bus.O_STAT_DB = 8'h00;
`endif

endmodule

// File: tb/tb_dkong3_snd_cmd_latch.sv
// -----------------------------------------------------------------------------
// tb_dkong3_snd_cmd_latch
// Directed bench for the sound-command mailbox (both status build options).
// -----------------------------------------------------------------------------
module tb_dkong3_snd_cmd_latch;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   dkong3_snd_cmd_latch_if #(.NUM_CH(2)) bus ();

   dkong3_snd_cmd_latch #(.NUM_CH(2)) dut (
      .I_CLK12M (clk),
      .I_RESET  (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected status bytes depend on the build option.
`ifdef DKONG3_SNDLATCH_STATUS_EN
   localparam logic [7:0] ST_OVR1    = 8'h22;
   localparam logic [7:0] ST_CLR1    = 8'h02;
   localparam logic [7:0] ST_OVR0    = 8'h13;
   localparam logic [7:0] ST_CLR0    = 8'h03;
`else
   localparam logic [7:0] ST_OVR1    = 8'h00;
   localparam logic [7:0] ST_CLR1    = 8'h00;
   localparam logic [7:0] ST_OVR0    = 8'h00;
   localparam logic [7:0] ST_CLR0    = 8'h00;
`endif

   initial begin
      bus.I_DB         = 8'h00;
      bus.I_WR_STB_n   = 2'b11;
      bus.I_SUB_RESETn = 2'b11;
      bus.I_SUB_RD_n   = 2'b11;
      bus.I_STAT_RD_n  = 1'b1;

      // Reset state
      step(); step(); step();
      chk("rst_db",   bus.O_SUB_DB,           16'h0000);
      chk("rst_pend", 16'(bus.O_PEND),        16'h0000);
      chk("rst_irq",  16'(bus.O_SUB_IRQ_n),   16'h0003);
      chk("rst_stat", 16'(bus.O_STAT_DB),     16'h0000);
      rst = 1'b0;
      step(); step();

      // Write A5 to channel 0, visible at first edge with strobe low
      bus.I_DB = 8'hA5; bus.I_WR_STB_n = 2'b10;
      step();
      chk("wr0_db",   16'(bus.O_SUB_DB[7:0]), 16'h00A5);
      chk("wr0_pend", 16'(bus.O_PEND),        16'h0001);
      chk("wr0_irq",  16'(bus.O_SUB_IRQ_n),   16'h0002);
      bus.I_WR_STB_n = 2'b11;
      step();

      // Sub-CPU 0 read, 3 cycles low: pend holds until the rising edge is seen
      bus.I_SUB_RD_n = 2'b10;
      step(); step(); step();
      chk("rd0_hold", 16'(bus.O_PEND),        16'h0001);
      bus.I_SUB_RD_n = 2'b11;
      step();
      chk("rd0_pend", 16'(bus.O_PEND),        16'h0000);
      chk("rd0_irq",  16'(bus.O_SUB_IRQ_n),   16'h0003);
      chk("rd0_db",   16'(bus.O_SUB_DB[7:0]), 16'h00A5);

      // Two writes to channel 1 without a read: overrun
      bus.I_DB = 8'h11; bus.I_WR_STB_n = 2'b01; step();
      bus.I_WR_STB_n = 2'b11; step();
      bus.I_DB = 8'h22; bus.I_WR_STB_n = 2'b01; step();
      bus.I_WR_STB_n = 2'b11; step();
      chk("ovr1_db",   16'(bus.O_SUB_DB[15:8]), 16'h0022);
      chk("ovr1_pend", 16'(bus.O_PEND),         16'h0002);
      chk("stat_idle", 16'(bus.O_STAT_DB),      16'h0000);
      bus.I_STAT_RD_n = 1'b0; #1;
      chk("stat_ovr1", 16'(bus.O_STAT_DB),      16'(ST_OVR1));
      step();
      bus.I_STAT_RD_n = 1'b1; step();
      bus.I_STAT_RD_n = 1'b0; #1;
      chk("stat_clr1", 16'(bus.O_STAT_DB),      16'(ST_CLR1));
      step();
      bus.I_STAT_RD_n = 1'b1; step();

      // Simultaneous write fall and read rise on channel 0: write wins
      bus.I_DB = 8'h33; bus.I_WR_STB_n = 2'b10; step();
      bus.I_WR_STB_n = 2'b11; step();
      bus.I_SUB_RD_n = 2'b10; step();
      bus.I_SUB_RD_n = 2'b11; bus.I_DB = 8'h44; bus.I_WR_STB_n = 2'b10;
      step();
      chk("sim_db",   16'(bus.O_SUB_DB[7:0]), 16'h0044);
      chk("sim_pend", 16'(bus.O_PEND),        16'h0003);
      chk("sim_irq",  16'(bus.O_SUB_IRQ_n),   16'h0000);
      bus.I_WR_STB_n = 2'b11; step();
      bus.I_STAT_RD_n = 1'b0; #1;
      chk("stat_ovr0", 16'(bus.O_STAT_DB),    16'(ST_OVR0));
      step();
      bus.I_STAT_RD_n = 1'b1; step();
      bus.I_STAT_RD_n = 1'b0; #1;
      chk("stat_clr0", 16'(bus.O_STAT_DB),    16'(ST_CLR0));
      step();
      bus.I_STAT_RD_n = 1'b1; step();

      // Sub reset on channel 1 with a write pulse during it
      bus.I_SUB_RESETn = 2'b01; step();
      chk("srst_db1",   16'(bus.O_SUB_DB[15:8]), 16'h0000);
      chk("srst_pend",  16'(bus.O_PEND),         16'h0001);
      bus.I_DB = 8'h77; bus.I_WR_STB_n = 2'b01; step();
      bus.I_WR_STB_n = 2'b11; step();
      chk("srst_wr_db", 16'(bus.O_SUB_DB[15:8]), 16'h0000);
      chk("srst_irq",   16'(bus.O_SUB_IRQ_n),    16'h0002);
      chk("srst_db0",   16'(bus.O_SUB_DB[7:0]),  16'h0044);
      bus.I_SUB_RESETn = 2'b11; step();
      chk("srst_rel",   16'(bus.O_PEND),         16'h0001);

      // I_RESET mid-write: asynchronous clear, then no event from held strobe
      bus.I_DB = 8'h55; bus.I_WR_STB_n = 2'b10;
      #2 rst = 1'b1;
      #1;
      chk("arst_db",   bus.O_SUB_DB,         16'h0000);
      chk("arst_pend", 16'(bus.O_PEND),      16'h0000);
      chk("arst_irq",  16'(bus.O_SUB_IRQ_n), 16'h0003);
      step();
      rst = 1'b0;
      step(); step();
      chk("held_pend", 16'(bus.O_PEND),      16'h0000);
      chk("held_db",   bus.O_SUB_DB,         16'h0000);
      bus.I_WR_STB_n = 2'b11; step();
      bus.I_DB = 8'h66; bus.I_WR_STB_n = 2'b10; step();
      chk("rearm_db",   16'(bus.O_SUB_DB[7:0]), 16'h0066);
      chk("rearm_pend", 16'(bus.O_PEND),        16'h0001);
      bus.I_WR_STB_n = 2'b11; step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
